// File: rtl/joy_serial_scan.sv
// Serial joystick chain reader: divided JOY_CLK, a load slot, a settle slot, then TOTAL data slots.
// Completed frames are published atomically, optionally only once two consecutive captures agree.
module joy_serial_scan #(
    parameter int NUM_CH      = 2,
    parameter int BITS_PER_CH = 12,
    parameter int DIV         = 16,
    parameter int FILTER      = 1
) (
    input  logic                          clk_12,
    input  logic                          RESET_L,
    output logic                          joy_clk,
    output logic                          joy_load,
    input  logic                          joy_data,
    output logic [NUM_CH*BITS_PER_CH-1:0] joy_out,
    output logic                          frame_done,
    output logic                          frame_upd
);

    localparam int TOTAL = NUM_CH * BITS_PER_CH;
    localparam int FRAME = TOTAL + 2;
    localparam int DCW   = $clog2(2 * DIV);
    localparam int SW    = $clog2(FRAME);

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(2 * DIV - 1);
    localparam logic [DCW-1:0] DIV_RISE  = DCW'(DIV - 1);
    localparam logic [DCW-1:0] DIV_HIGH  = DCW'(DIV);
    localparam logic [DCW-1:0] DIV_ONE   = DCW'(1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(FRAME - 1);
    localparam logic [SW-1:0]  SLOT_DATA = SW'(2);
    localparam logic [SW-1:0]  SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0]  SLOT_ZERO = SW'(0);
    localparam bit             FILTER_ON = (FILTER != 32'sd0);

    logic [DCW-1:0]   div_cnt_q, div_cnt_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [TOTAL-1:0] shift_q, shift_d;
    logic [TOTAL-1:0] prev_q, prev_d;
    logic [TOTAL-1:0] joy_out_q, joy_out_d;
    logic             joy_clk_q, joy_clk_d;
    logic             joy_load_q, joy_load_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_upd_q, frame_upd_d;

    logic             rise_s;
    logic [TOTAL:0]   capture_ext_s;
    logic [TOTAL-1:0] capture_s;

    // Next-state: divider, slot sequencing, serial shift and end-of-frame publish decision
    always_comb begin
        div_cnt_d     = div_cnt_q;
        slot_d        = slot_q;
        shift_d       = shift_q;
        prev_d        = prev_q;
        joy_out_d     = joy_out_q;
        frame_done_d  = 1'b0;
        frame_upd_d   = 1'b0;
        rise_s        = (div_cnt_q == DIV_RISE);
        capture_ext_s = {shift_q, joy_data};
        capture_s     = capture_ext_s[TOTAL-1:0];

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end

        if (rise_s) begin
            if (slot_q == SLOT_LAST) begin
                slot_d = SLOT_ZERO;
            end else begin
                slot_d = slot_q + SLOT_ONE;
            end

            // The final data bit is folded straight into the capture so it is never lost.
            if (slot_q >= SLOT_DATA) begin
                shift_d = capture_s;
            end else begin
                shift_d = shift_q;
            end

            if (slot_q == SLOT_LAST) begin
                frame_done_d = 1'b1;
                prev_d       = capture_s;
                if (!FILTER_ON || (capture_s == prev_q)) begin
                    joy_out_d   = capture_s;
                    frame_upd_d = 1'b1;
                end else begin
                    joy_out_d   = joy_out_q;
                    frame_upd_d = 1'b0;
                end
            end else begin
                frame_done_d = 1'b0;
            end
        end else begin
            slot_d = slot_q;
        end

        joy_clk_d  = (div_cnt_d >= DIV_HIGH);
        joy_load_d = (slot_d != SLOT_ZERO);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk_12) begin
        if (!RESET_L) begin
            div_cnt_q    <= '0;
            slot_q       <= '0;
            shift_q      <= '1;
            prev_q       <= '1;
            joy_out_q    <= '1;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            frame_done_q <= 1'b0;
            frame_upd_q  <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            slot_q       <= slot_d;
            shift_q      <= shift_d;
            prev_q       <= prev_d;
            joy_out_q    <= joy_out_d;
            joy_clk_q    <= joy_clk_d;
            joy_load_q   <= joy_load_d;
            frame_done_q <= frame_done_d;
            frame_upd_q  <= frame_upd_d;
        end
    end

    assign joy_clk    = joy_clk_q;
    assign joy_load   = joy_load_q;
    assign joy_out    = joy_out_q;
    assign frame_done = frame_done_q;
    assign frame_upd  = frame_upd_q;

endmodule
